// File: rtl/vscale_htif_pcr_host.sv
// Host-side HTIF PCR initiator: polls tohost, clears it, and reports pass/fail.
// It also forwards one external CSR command at a time.
module vscale_htif_pcr_host #(
   parameter int                ADDR_W        = 12,
   parameter int                DATA_W        = 64,
   parameter logic [ADDR_W-1:0] TOHOST_ADDR   = 12'h780,
   parameter int                POLL_INTERVAL = 16,
   parameter int                TIMEOUT       = 1024
) (
   input  logic              clk,
   input  logic              reset,
   output logic              htif_pcr_req_valid,
   input  logic              htif_pcr_req_ready,
   output logic              htif_pcr_req_rw,
   output logic [ADDR_W-1:0] htif_pcr_req_addr,
   output logic [DATA_W-1:0] htif_pcr_req_data,
   input  logic              htif_pcr_resp_valid,
   output logic              htif_pcr_resp_ready,
   input  logic [DATA_W-1:0] htif_pcr_resp_data,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_rw,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,
   output logic              cmd_rsp_valid,
   output logic [DATA_W-1:0] cmd_rsp_data,
   output logic              done,
   output logic              pass,
   output logic [DATA_W-2:0] fail_code,
   output logic              timeout_err
);

   localparam int PW = $clog2(POLL_INTERVAL + 1);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [PW-1:0] POLL_RELOAD  = PW'(POLL_INTERVAL - 1);
   localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT - 1);

   typedef enum logic [2:0] {IDLE, REQ, RESP, CLEAR_REQ, CLEAR_RESP, HALT} state_t;

   state_t            state, state_next;
   logic [PW-1:0]     poll_cnt;
   logic [TW-1:0]     to_cnt;
   logic              src_ext;
   logic              req_rw;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_data;
   logic [DATA_W-1:0] latched;
   logic              cmd_take, poll_go, busy, to_hit, req_fire, resp_fire;

   assign htif_pcr_req_valid  = (state == REQ) || (state == CLEAR_REQ);
   assign htif_pcr_resp_ready = (state == RESP) || (state == CLEAR_RESP);
   assign htif_pcr_req_rw     = htif_pcr_req_valid ? req_rw : 1'b0;
   assign htif_pcr_req_addr   = htif_pcr_req_valid ? req_addr : '0;
   assign htif_pcr_req_data   = htif_pcr_req_valid ? req_data : '0;
   assign cmd_ready           = cmd_take;

   // A finished response takes priority over a timeout landing on the same cycle.
   always_comb begin
      state_next = state;
      cmd_take   = 1'b0;
      poll_go    = 1'b0;
      req_fire   = htif_pcr_req_valid && htif_pcr_req_ready;
      resp_fire  = htif_pcr_resp_ready && htif_pcr_resp_valid;
      busy       = (state == REQ) || (state == RESP) || (state == CLEAR_REQ) || (state == CLEAR_RESP);
      to_hit     = busy && (to_cnt >= TIMEOUT_LAST);
      case (state)
         IDLE: begin
            if (cmd_valid) begin
               cmd_take   = 1'b1;
               state_next = REQ;
            end else if ((poll_cnt == '0) && !done) begin
               poll_go    = 1'b1;
               state_next = REQ;
            end
         end
         REQ: begin
            if (to_hit)        state_next = HALT;
            else if (req_fire) state_next = RESP;
         end
         RESP: begin
            if (resp_fire)
               state_next = (src_ext || (htif_pcr_resp_data == '0)) ? IDLE : CLEAR_REQ;
            else if (to_hit)
               state_next = HALT;
         end
         CLEAR_REQ: begin
            if (to_hit)        state_next = HALT;
            else if (req_fire) state_next = CLEAR_RESP;
         end
         CLEAR_RESP: begin
            if (resp_fire)   state_next = IDLE;
            else if (to_hit) state_next = HALT;
         end
         default: state_next = HALT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         poll_cnt      <= POLL_RELOAD;
         to_cnt        <= '0;
         src_ext       <= 1'b0;
         req_rw        <= 1'b0;
         req_addr      <= '0;
         req_data      <= '0;
         latched       <= '0;
         cmd_rsp_valid <= 1'b0;
         cmd_rsp_data  <= '0;
         done          <= 1'b0;
         pass          <= 1'b0;
         fail_code     <= '0;
         timeout_err   <= 1'b0;
      end else begin
         state         <= state_next;
         cmd_rsp_valid <= 1'b0;
         if ((state == IDLE) && (poll_cnt != '0))
            poll_cnt <= poll_cnt - PW'(1);
         if (poll_go) begin
            poll_cnt <= POLL_RELOAD;
            src_ext  <= 1'b0;
            req_rw   <= 1'b0;
            req_addr <= TOHOST_ADDR;
            req_data <= '0;
         end
         if (cmd_take) begin
            src_ext  <= 1'b1;
            req_rw   <= cmd_rw;
            req_addr <= cmd_addr;
            req_data <= cmd_rw ? cmd_wdata : '0;
         end
         // The clearing write is staged here so CLEAR_REQ presents it immediately.
         if ((state == RESP) && resp_fire) begin
            if (src_ext) begin
               cmd_rsp_valid <= 1'b1;
               cmd_rsp_data  <= htif_pcr_resp_data;
            end else if (htif_pcr_resp_data != '0) begin
               latched  <= htif_pcr_resp_data;
               req_rw   <= 1'b1;
               req_addr <= TOHOST_ADDR;
               req_data <= '0;
            end
         end
         if ((state == CLEAR_RESP) && resp_fire) begin
            done      <= 1'b1;
            pass      <= (latched == DATA_W'(1));
            fail_code <= (latched == DATA_W'(1)) ? '0 : latched[DATA_W-1:1];
         end
         if (((state_next == REQ) && (state != REQ)) || ((state_next == CLEAR_REQ) && (state != CLEAR_REQ)))
            to_cnt <= '0;
         else if (busy)
            to_cnt <= to_cnt + TW'(1);
         if ((state_next == HALT) && (state != HALT))
            timeout_err <= 1'b1;
      end
   end

endmodule
